// File: rtl/ir_avoid_ctrl_if.sv
// Control-side bundle between the IR sensor pins, the avoidance sequencer and the motor driver.
interface ir_avoid_ctrl_if;
  logic       enable;
  logic       sense_l_;
  logic       sense_m_;
  logic       sense_r_;
  logic [2:0] obstacle;
  logic [2:0] motor_cmd;
  logic [2:0] state;
  logic       busy;

  modport master (
    output enable, sense_l_, sense_m_, sense_r_,
    input  obstacle, motor_cmd, state, busy
  );

  modport slave (
    input  enable, sense_l_, sense_m_, sense_r_,
    output obstacle, motor_cmd, state, busy
  );
endinterface

// File: rtl/ir_avoid_ctrl.sv
// Obstacle-avoidance sequencer: sync + debounce three active-low IR lines, then run
// DRIVE/HALT/BACK/TURN phases and issue one registered motor command.
module ir_avoid_ctrl #(
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int HALT_CYCLES     = 50000,
  parameter int BACK_CYCLES     = 200000,
  parameter int TURN_CYCLES     = 150000
) (
  input logic             clk,
  input logic             rst,
  ir_avoid_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_HALT  = 3'd2,
    ST_BACK  = 3'd3,
    ST_TURN  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CMD_STOP   = 3'd0,
    CMD_FWD    = 3'd1,
    CMD_BACK   = 3'd2,
    CMD_TURN_L = 3'd3,
    CMD_TURN_R = 3'd4
  } cmd_e;

  localparam logic             DIR_LEFT  = 1'b0;
  localparam logic             DIR_RIGHT = 1'b1;
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALT_LAST = CNT_W'(HALT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BACK_LAST = CNT_W'(BACK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);

  // Channel index 2 = left, 1 = mid, 0 = right, matching the obstacle bit order.
  logic [2:0]            raw;
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            deb_q, deb_d;
  logic [2:0][CNT_W-1:0] dcnt_q, dcnt_d;
  logic [2:0]            obs;

  state_e           state_q, state_d;
  cmd_e             cmd_q, cmd_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             turn_dir_q, turn_dir_d;
  logic             alt_q, alt_d;
  logic             need_back_q, need_back_d;
  logic             lat_dir, lat_toggle;

  assign raw = {bus.sense_l_, bus.sense_m_, bus.sense_r_};
  assign obs = ~deb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      dcnt_q  <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + ONE;
        end
      end
    end
  end

  // Steer away from a single-sided obstacle; ambiguous patterns alternate sides.
  always_comb begin
    lat_dir    = alt_q;
    lat_toggle = 1'b0;
    case (obs)
      3'b100, 3'b110: lat_dir = DIR_RIGHT;
      3'b001, 3'b011: lat_dir = DIR_LEFT;
      default: begin
        lat_dir    = alt_q;
        lat_toggle = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    turn_dir_d  = turn_dir_q;
    alt_d       = alt_q;
    need_back_d = need_back_q;
    cmd_d       = CMD_STOP;
    busy_d      = 1'b0;
    // Saturate so a long DRIVE or IDLE stretch cannot wrap the timer.
    timer_d     = (timer_q == '1) ? timer_q : timer_q + ONE;

    if (!bus.enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_DRIVE;
        ST_DRIVE: begin
          if (obs != 3'b000) begin
            state_d     = ST_HALT;
            turn_dir_d  = lat_dir;
            alt_d       = alt_q ^ lat_toggle;
            need_back_d = obs[1] | (obs[2] & obs[0]);
          end
        end
        ST_HALT: begin
          if (timer_q == HALT_LAST) state_d = need_back_q ? ST_BACK : ST_TURN;
        end
        ST_BACK: begin
          if (timer_q == BACK_LAST) state_d = ST_TURN;
        end
        ST_TURN: begin
          if (timer_q == TURN_LAST) begin
            if (obs == 3'b000) begin
              state_d = ST_DRIVE;
            end else begin
              state_d     = ST_HALT;
              turn_dir_d  = lat_dir;
              alt_d       = alt_q ^ lat_toggle;
              need_back_d = obs[1] | (obs[2] & obs[0]);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (!bus.enable || (state_d != state_q)) timer_d = '0;

    unique case (state_d)
      ST_DRIVE: cmd_d = CMD_FWD;
      ST_BACK:  cmd_d = CMD_BACK;
      ST_TURN:  cmd_d = (turn_dir_d == DIR_RIGHT) ? CMD_TURN_R : CMD_TURN_L;
      default:  cmd_d = CMD_STOP;
    endcase
    busy_d = (state_d == ST_HALT) || (state_d == ST_BACK) || (state_d == ST_TURN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_STOP;
      busy_q      <= 1'b0;
      timer_q     <= '0;
      turn_dir_q  <= DIR_LEFT;
      alt_q       <= 1'b0;
      need_back_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      busy_q      <= busy_d;
      timer_q     <= timer_d;
      turn_dir_q  <= turn_dir_d;
      alt_q       <= alt_d;
      need_back_q <= need_back_d;
    end
  end

  assign bus.obstacle  = obs;
  assign bus.motor_cmd = cmd_q;
  assign bus.state     = state_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ir_avoid_ctrl.sv
// Directed bench for ir_avoid_ctrl with short phase lengths (DEBOUNCE=4, HALT=3, BACK=5, TURN=6).
module tb_ir_avoid_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_DRIVE = 3'd1, S_HALT = 3'd2, S_BACK = 3'd3, S_TURN = 3'd4;
  localparam logic [2:0] C_STOP = 3'd0, C_FWD = 3'd1, C_BACK = 3'd2, C_TL = 3'd3, C_TR = 3'd4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  ir_avoid_ctrl_if bus ();

  ir_avoid_ctrl #(
    .CNT_W(20), .DEBOUNCE_CYCLES(4), .HALT_CYCLES(3), .BACK_CYCLES(5), .TURN_CYCLES(6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] st, input logic [2:0] cmd, input logic bsy);
    chk({tag, "_state"}, {5'd0, bus.state}, {5'd0, st});
    chk({tag, "_cmd"},   {5'd0, bus.motor_cmd}, {5'd0, cmd});
    chk({tag, "_busy"},  {7'd0, bus.busy}, {7'd0, bsy});
  endtask

  initial begin
    rst = 1'b0;
    bus.enable = 1'b0;
    bus.sense_l_ = 1'b1;
    bus.sense_m_ = 1'b1;
    bus.sense_r_ = 1'b1;
    tick(2);
    chk_st("reset", S_IDLE, C_STOP, 1'b0);
    chk("reset_obs", {5'd0, bus.obstacle}, 8'h00);
    rst = 1'b1;
    tick(1);
    chk("idle_no_enable", {5'd0, bus.state}, {5'd0, S_IDLE});

    // 1: enable -> DRIVE one cycle later
    bus.enable = 1'b1;
    tick(1);
    chk_st("drive_start", S_DRIVE, C_FWD, 1'b0);
    chk("drive_obs", {5'd0, bus.obstacle}, 8'h00);

    // 2: three-cycle glitch is filtered
    bus.sense_l_ = 1'b0;
    tick(3);
    bus.sense_l_ = 1'b1;
    tick(8);
    chk("glitch_obs", {5'd0, bus.obstacle}, 8'h00);
    chk("glitch_cmd", {5'd0, bus.motor_cmd}, {5'd0, C_FWD});

    // 2/3: six-cycle low -> obstacle 100 at edge 6, left-only avoidance
    bus.sense_l_ = 1'b0;
    tick(5);
    chk("deb_edge5_obs", {5'd0, bus.obstacle}, 8'h00);
    tick(1);
    chk("deb_edge6_obs", {5'd0, bus.obstacle}, 8'h04);
    chk("deb_edge6_state", {5'd0, bus.state}, {5'd0, S_DRIVE});
    bus.sense_l_ = 1'b1;
    tick(1);
    chk_st("left_halt", S_HALT, C_STOP, 1'b1);
    tick(2);
    chk_st("left_halt_end", S_HALT, C_STOP, 1'b1);
    tick(1);
    chk_st("left_turn", S_TURN, C_TR, 1'b1);
    tick(1);
    chk("left_clear_e11", {5'd0, bus.obstacle}, 8'h04);
    tick(1);
    chk("left_clear_e12", {5'd0, bus.obstacle}, 8'h00);
    tick(3);
    chk_st("left_turn_end", S_TURN, C_TR, 1'b1);
    tick(1);
    chk_st("left_redrive", S_DRIVE, C_FWD, 1'b0);

    // 4a: mid-only -> HALT, BACK, TURN_L (alt 0)
    bus.sense_m_ = 1'b0;
    tick(6);
    chk("mid1_obs", {5'd0, bus.obstacle}, 8'h02);
    bus.sense_m_ = 1'b1;
    tick(1);
    chk_st("mid1_halt", S_HALT, C_STOP, 1'b1);
    tick(2);
    chk_st("mid1_halt_end", S_HALT, C_STOP, 1'b1);
    tick(1);
    chk_st("mid1_back", S_BACK, C_BACK, 1'b1);
    tick(4);
    chk_st("mid1_back_end", S_BACK, C_BACK, 1'b1);
    tick(1);
    chk_st("mid1_turn", S_TURN, C_TL, 1'b1);
    tick(6);
    chk_st("mid1_redrive", S_DRIVE, C_FWD, 1'b0);

    // 4b: mid-only again -> TURN_R (alt toggled)
    bus.sense_m_ = 1'b0;
    tick(6);
    bus.sense_m_ = 1'b1;
    tick(1);
    chk_st("mid2_halt", S_HALT, C_STOP, 1'b1);
    tick(3);
    chk_st("mid2_back", S_BACK, C_BACK, 1'b1);
    bus.sense_r_ = 1'b0;
    tick(5);
    chk_st("mid2_turn", S_TURN, C_TR, 1'b1);

    // 5: right obstacle appears during TURN, phase not cut short, re-latch to left
    tick(5);
    chk("turn_obs_right", {5'd0, bus.obstacle}, 8'h01);
    chk_st("turn_not_cut", S_TURN, C_TR, 1'b1);
    tick(1);
    chk_st("rehalt", S_HALT, C_STOP, 1'b1);
    bus.sense_m_ = 1'b0;
    tick(2);
    chk_st("rehalt_end", S_HALT, C_STOP, 1'b1);
    tick(1);
    chk_st("rehalt_turn_l", S_TURN, C_TL, 1'b1);
    tick(5);
    chk("obs_mid_right", {5'd0, bus.obstacle}, 8'h03);
    chk_st("turn2_end", S_TURN, C_TL, 1'b1);
    tick(1);
    chk_st("rehalt2", S_HALT, C_STOP, 1'b1);
    tick(3);
    chk_st("rehalt2_back", S_BACK, C_BACK, 1'b1);

    // 6a: enable dropped in second BACK cycle
    tick(1);
    chk_st("back_cycle2", S_BACK, C_BACK, 1'b1);
    bus.enable = 1'b0;
    tick(1);
    chk_st("disable_idle", S_IDLE, C_STOP, 1'b0);
    bus.enable = 1'b1;
    tick(1);
    chk_st("reenable_drive", S_DRIVE, C_FWD, 1'b0);
    tick(1);
    chk_st("reenable_halt", S_HALT, C_STOP, 1'b1);
    tick(3);
    chk_st("reenable_back", S_BACK, C_BACK, 1'b1);
    tick(5);
    chk_st("reenable_turn", S_TURN, C_TL, 1'b1);
    tick(1);

    // 6b: async reset mid-TURN
    #2;
    rst = 1'b0;
    #1;
    chk_st("async_rst", S_IDLE, C_STOP, 1'b0);
    chk("async_rst_obs", {5'd0, bus.obstacle}, 8'h00);
    bus.sense_m_ = 1'b1;
    bus.sense_r_ = 1'b1;
    tick(1);
    chk("rst_held_idle", {5'd0, bus.state}, {5'd0, S_IDLE});
    rst = 1'b1;
    tick(1);
    chk_st("post_rst_drive", S_DRIVE, C_FWD, 1'b0);
    chk("post_rst_obs", {5'd0, bus.obstacle}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ir_avoid_ctrl.md
Name: ir_avoid_ctrl

Overview:
- Obstacle-avoidance sequencer for the cart. Takes three raw active-low IR sense lines (left, middle, right) and synchronizes and debounces each one.
- Runs a drive/halt/back-up/turn state machine from the debounced obstacles and issues one registered motor command to the motor driver.
- Sits between the IR sensor pins and the motor-control block; it is the only source of motion commands while enable is high.

Parameters:
- CNT_W, 20, width of the debounce and phase timer counters
- DEBOUNCE_CYCLES, 5000, cycles a synchronized input must hold a new level before the debounced level changes (>=1)
- HALT_CYCLES, 50000, cycles spent stopped after an obstacle is detected (>=1)
- BACK_CYCLES, 200000, cycles spent reversing (>=1)
- TURN_CYCLES, 150000, cycles spent turning (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- enable  in  1  1 = autonomous driving allowed; 0 = forced stop
- sense_l_  in  1  raw left IR output, low = obstacle, asynchronous
- sense_m_  in  1  raw middle IR output, low = obstacle, asynchronous
- sense_r_  in  1  raw right IR output, low = obstacle, asynchronous
- obstacle  out  3  debounced obstacle flags {left, mid, right}, 1 = obstacle
- motor_cmd  out  3  registered command: 0 STOP, 1 FWD, 2 BACK, 3 TURN_L, 4 TURN_R; 5-7 never driven
- state  out  3  current FSM state: 0 IDLE, 1 DRIVE, 2 HALT, 3 BACK, 4 TURN
- busy  out  1  1 while state is HALT, BACK or TURN

Behaviour:
- Reset (rst=0, async) sets: synchronizer flops=1, debounced levels=1 (obstacle=000), debounce counters=0, timer=0, state=IDLE, motor_cmd=STOP, turn_dir=left, alt bit=0.
- All outputs are registered. motor_cmd and busy are updated in the same cycle as state.
- Synchronizer: two flops per sense line.
- Debounce, per channel:
  - If the sync value differs from the debounced level, increment the counter.
  - When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the debounced level takes the sync value and the counter clears.
  - If the values are equal, the counter clears.
  - obstacle = ~debounced level.
  - Latency from a raw edge to an obstacle change is 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Phase timer: one shared counter, cleared on every state transition, incremented otherwise. A phase "expires" when timer == X_CYCLES-1, so each phase lasts exactly X_CYCLES cycles.
- FSM transitions (priority: enable=0 first):
  - Any state, enable=0: next cycle IDLE, cmd STOP, timer cleared.
  - IDLE, enable=1: DRIVE, cmd FWD.
  - DRIVE, obstacle!=000: HALT, cmd STOP. turn_dir is latched at this moment:
    - left only, or left+mid: turn_dir=right
    - right only, or right+mid: turn_dir=left
    - any other non-zero pattern (mid only, left+right, all three): turn_dir=alt, then alt toggles
  - HALT, expired: BACK if the mid flag was set at HALT entry (need_back flag) or both sides were set; otherwise TURN.
  - BACK, expired: TURN, cmd TURN_L or TURN_R per turn_dir.
  - TURN, expired: DRIVE if obstacle==000; else HALT with turn_dir re-latched by the same rules.
  - DRIVE with obstacle==000: stay in DRIVE.
- Obstacle changes during HALT, BACK or TURN do not cut the phase short.
- A simultaneous enable fall and phase expiry goes to IDLE.
- Reset asserted mid-phase forces all reset values immediately. After release, the first DRIVE needs enable=1.
- The counter widths must hold the largest parameter minus 1. Counters never wrap in normal operation.

Test Plan:
(Bench parameters: DEBOUNCE=4, HALT=3, BACK=5, TURN=6.)
1. Reset, then enable=1 with all sense_=1 -> state IDLE→DRIVE one cycle after enable, motor_cmd=1, obstacle=000, busy=0.
2. sense_l_ pulled low for 3 cycles, then back high -> obstacle stays 000 and motor_cmd stays 1. Held low for 6 cycles -> obstacle=100 at 2+4 cycles after the edge.
3. Left-only obstacle while in DRIVE -> HALT with cmd 0 for exactly 3 cycles, then TURN with cmd 4 (TURN_R) for 6 cycles. Clearing the obstacle before TURN expiry -> DRIVE, cmd 1.
4. Mid-only obstacle, twice in succession -> HALT 3 cycles → BACK (cmd 2) 5 cycles → TURN. The first turn is TURN_L (cmd 3) and the second is TURN_R (cmd 4), showing alt toggling.
5. Obstacle still present at TURN expiry -> HALT again, busy stays 1, turn_dir re-latched.
6. enable dropped in cycle 2 of BACK -> next cycle IDLE, cmd 0, busy 0. Separately, rst pulsed low mid-TURN -> outputs are at reset values asynchronously.
